// File: rtl/ln_sched_pkg.sv
// Shared types and sizing for the LayerNorm bank scheduler.
package ln_sched_pkg;
    localparam int NUM_BANKS       = 4;
    localparam int BEATS_PER_TOKEN = 12;
    localparam int BANK_W          = $clog2(NUM_BANKS);
    localparam int BEAT_W          = $clog2(BEATS_PER_TOKEN);

    typedef enum logic [2:0] {FREE, FILL, PEND, STATS, READY} bank_state_e;
    typedef logic [BANK_W-1:0] bank_idx_t;
    typedef logic [BEAT_W-1:0] beat_idx_t;
endpackage

// File: rtl/ln_ring_cursor.sv
// Bank ring pointer with an optional beat counter; the bank advances when the
// last beat of a token is consumed (every advance in bank-only mode).
module ln_ring_cursor
    import ln_sched_pkg::*;
#(
    parameter bit BANK_ONLY = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_adv,
    output logic [BANK_W-1:0] bank,
    output logic [BEAT_W-1:0] beat,
    output logic              last
);
    assign last = BANK_ONLY ? 1'b1 : (beat == BEAT_W'(BEATS_PER_TOKEN - 1));

    // NUM_BANKS is a power of two, so the bank index wraps on its own
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bank <= '0;
            beat <= '0;
        end else if (i_adv) begin
            if (last) begin
                beat <= '0;
                bank <= bank + 1'b1;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ln_bank_scheduler.sv
// Four-bank token scheduler: fill -> stats -> normalize drain, with valid/ready
// at ingress and egress and tokens leaving in arrival order.
module ln_bank_scheduler
    import ln_sched_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [BANK_W-1:0] o_wr_bank,
    output logic [BEAT_W-1:0] o_wr_beat,
    output logic              o_acc_first,
    output logic              o_stats_start,
    output logic [BANK_W-1:0] o_stats_bank,
    input  logic              i_stats_done,
    input  logic [BANK_W-1:0] i_stats_bank,
    output logic              o_norm_valid,
    output logic [BANK_W-1:0] o_norm_bank,
    output logic [BEAT_W-1:0] o_norm_beat,
    output logic              o_norm_last,
    input  logic              i_norm_ready,
    output logic              o_err,
    output logic [15:0]       o_tok_in,
    output logic [15:0]       o_tok_out
);
    bank_state_e       bank_st   [NUM_BANKS];
    bank_state_e       bank_st_n [NUM_BANKS];
    logic [BANK_W-1:0] wr_bank, st_bank, rd_bank, rd_bank_n;
    logic [BEAT_W-1:0] wr_beat, rd_beat, st_beat_unused;
    logic              wr_last, rd_last, st_last_unused;
    logic              stats_busy, norm_vld_p0;
    logic              start_n, done_ok, norm_fire, drain_done;

    ln_ring_cursor #(.BANK_ONLY(1'b0)) u_wr (.i_clk(i_clk), .i_rst(i_rst), .i_adv(o_wr_en),
        .bank(wr_bank), .beat(wr_beat), .last(wr_last));
    ln_ring_cursor #(.BANK_ONLY(1'b1)) u_st (.i_clk(i_clk), .i_rst(i_rst), .i_adv(done_ok),
        .bank(st_bank), .beat(st_beat_unused), .last(st_last_unused));
    ln_ring_cursor #(.BANK_ONLY(1'b0)) u_rd (.i_clk(i_clk), .i_rst(i_rst), .i_adv(norm_fire),
        .bank(rd_bank), .beat(rd_beat), .last(rd_last));

    assign o_in_ready  = i_en & ((bank_st[wr_bank] == FREE) | (bank_st[wr_bank] == FILL));
    assign o_wr_en     = i_in_valid & o_in_ready;
    assign o_wr_bank   = wr_bank;
    assign o_wr_beat   = wr_beat;
    assign o_acc_first = o_wr_en & (wr_beat == '0);

    // The drain request is registered; i_en only masks it so a held beat is never consumed while frozen
    assign o_norm_valid = norm_vld_p0 & i_en;
    assign o_norm_bank  = rd_bank;
    assign o_norm_beat  = rd_beat;
    assign o_norm_last  = o_norm_valid & rd_last;
    assign norm_fire    = o_norm_valid & i_norm_ready;
    assign drain_done   = norm_fire & rd_last;
    assign rd_bank_n    = drain_done ? rd_bank + 1'b1 : rd_bank;

    assign start_n = i_en & ~stats_busy & (bank_st[st_bank] == PEND);
    assign done_ok = i_stats_done & stats_busy & (i_stats_bank == st_bank)
                   & (bank_st[st_bank] == STATS);

    // Ingress, stats and drain always address different banks, so all updates compose
    always_comb begin
        bank_st_n = bank_st;
        if (o_wr_en)    bank_st_n[wr_bank] = wr_last ? PEND : FILL;
        if (start_n)    bank_st_n[st_bank] = STATS;
        if (done_ok)    bank_st_n[st_bank] = READY;
        if (drain_done) bank_st_n[rd_bank] = FREE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < NUM_BANKS; b++) bank_st[b] <= FREE;
            stats_busy    <= 1'b0;
            o_stats_start <= 1'b0;
            o_stats_bank  <= '0;
            norm_vld_p0   <= 1'b0;
            o_err         <= 1'b0;
            o_tok_in      <= '0;
            o_tok_out     <= '0;
        end else begin
            bank_st       <= bank_st_n;
            o_stats_start <= start_n;
            if (start_n) begin
                o_stats_bank <= st_bank;
                stats_busy   <= 1'b1;
            end else if (done_ok) begin
                stats_busy   <= 1'b0;
            end
            // Looking at next state lets the following READY bank drain without a bubble
            norm_vld_p0 <= (bank_st_n[rd_bank_n] == READY);
            if ((i_stats_done & ~done_ok) | (o_wr_en & drain_done & (wr_bank == rd_bank)))
                o_err <= 1'b1;
            if (o_wr_en & wr_last) o_tok_in  <= o_tok_in + 16'd1;
            if (drain_done)        o_tok_out <= o_tok_out + 16'd1;
        end
    end
endmodule

// File: tb/tb_ln_bank_scheduler.sv
// Randomized scoreboard bench for ln_bank_scheduler against a token-level queue model.
module tb_ln_bank_scheduler;
    import ln_sched_pkg::*;

    logic i_clk = 1'b0, i_rst, i_en, i_in_valid, i_stats_done, i_norm_ready;
    logic [BANK_W-1:0] i_stats_bank;
    logic o_in_ready, o_wr_en, o_acc_first, o_stats_start, o_norm_valid, o_norm_last, o_err;
    logic [BANK_W-1:0] o_wr_bank, o_stats_bank, o_norm_bank;
    logic [BEAT_W-1:0] o_wr_beat, o_norm_beat;
    logic [15:0] o_tok_in, o_tok_out;

    ln_bank_scheduler dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .o_wr_en(o_wr_en), .o_wr_bank(o_wr_bank),
        .o_wr_beat(o_wr_beat), .o_acc_first(o_acc_first), .o_stats_start(o_stats_start),
        .o_stats_bank(o_stats_bank), .i_stats_done(i_stats_done), .i_stats_bank(i_stats_bank),
        .o_norm_valid(o_norm_valid), .o_norm_bank(o_norm_bank), .o_norm_beat(o_norm_beat),
        .o_norm_last(o_norm_last), .i_norm_ready(i_norm_ready), .o_err(o_err),
        .o_tok_in(o_tok_in), .o_tok_out(o_tok_out));

    always #5 i_clk = ~i_clk;

    int total = 0, bad = 0;

    // stimulus knobs
    int budget = 0, valid_pct = 100, ready_pct = 100, en_drop_pct = 0, resp_delay = 5;
    bit en_low = 1'b1, inj_req = 1'b0;
    logic [BANK_W-1:0] inj_bank = '0;

    // reference model state
    int tok_in_m, tok_out_m, wr_part, rd_beat_m, rdy_cnt;
    int acc_total = 0, fire_total = 0;
    bit st_busy_m, err_m, can_start_prev, hold_prev;
    int st_cur;
    logic [BANK_W-1:0] hold_bank;
    logic [BEAT_W-1:0] hold_beat;
    int st_q[$];
    int drain_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        tok_in_m = 0; tok_out_m = 0; wr_part = 0; rd_beat_m = 0; rdy_cnt = 0;
        st_busy_m = 0; err_m = 0; can_start_prev = 0; hold_prev = 0; st_cur = 0;
        st_q.delete();
        drain_q.delete();
    endtask

    // Driver: ingress valid, egress ready and enable
    initial begin
        bit tog;
        tog = 0;
        i_en = 0; i_in_valid = 0; i_norm_ready = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst && i_in_valid && o_in_ready && budget > 0) budget--;
            @(posedge i_clk); #1;
            i_en       = !en_low && !($urandom_range(99) < en_drop_pct);
            i_in_valid = (budget != 0) && ($urandom_range(99) < valid_pct);
            tog        = !tog;
            i_norm_ready = (ready_pct < 0) ? tog : ($urandom_range(99) < ready_pct);
        end
    end

    // Stats-stage responder
    initial begin
        bit pend;
        int cnt;
        logic [BANK_W-1:0] rbank;
        pend = 0; cnt = 0; rbank = '0;
        i_stats_done = 0; i_stats_bank = '0;
        forever begin
            @(posedge i_clk); #2;
            i_stats_done = 0;
            if (i_rst) begin
                pend = 0;
                continue;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    i_stats_done = 1; i_stats_bank = rbank; pend = 0;
                end
            end
            if (!i_stats_done && inj_req) begin
                i_stats_done = 1; i_stats_bank = inj_bank; inj_req = 0;
            end
            if (o_stats_start) begin
                pend  = 1;
                rbank = o_stats_bank;
                cnt   = (resp_delay > 0) ? resp_delay : int'($urandom_range(6, 1));
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit exp_ready, exp_valid, acc, fire;
        model_clear();
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                model_clear();
                continue;
            end
            exp_ready = i_en && (wr_part != 0 || drain_q.size() < NUM_BANKS);
            exp_valid = i_en && (rdy_cnt > 0);
            acc  = i_in_valid && exp_ready;
            fire = exp_valid && i_norm_ready;
            chk("in_ready", o_in_ready, exp_ready);
            chk("wr_en", o_wr_en, acc);
            chk("norm_valid", o_norm_valid, exp_valid);
            chk("err", o_err, err_m);
            chk("tok_in", o_tok_in, 32'(tok_in_m[15:0]));
            chk("tok_out", o_tok_out, 32'(tok_out_m[15:0]));
            chk("stats_start", o_stats_start, can_start_prev);
            if (can_start_prev) begin
                st_cur = st_q.pop_front();
                st_busy_m = 1;
                if (o_stats_start) chk("stats_bank", o_stats_bank, st_cur);
            end
            can_start_prev = i_en && !st_busy_m && st_q.size() > 0;
            if (hold_prev && o_norm_valid) begin
                chk("hold_bank", o_norm_bank, hold_bank);
                chk("hold_beat", o_norm_beat, hold_beat);
            end
            chk("acc_first", o_acc_first, acc && wr_part == 0);
            if (acc) begin
                chk("wr_bank", o_wr_bank, tok_in_m % NUM_BANKS);
                chk("wr_beat", o_wr_beat, wr_part);
            end
            if (fire) begin
                chk("norm_bank", o_norm_bank, drain_q[0]);
                chk("norm_beat", o_norm_beat, rd_beat_m);
                chk("norm_last", o_norm_last, rd_beat_m == BEATS_PER_TOKEN - 1);
            end
            hold_prev = o_norm_valid && !i_norm_ready;
            hold_bank = o_norm_bank;
            hold_beat = o_norm_beat;
            if (i_stats_done) begin
                if (st_busy_m && i_stats_bank == BANK_W'(st_cur)) begin
                    st_busy_m = 0; rdy_cnt++;
                end else begin
                    err_m = 1;
                end
            end
            if (fire) begin
                fire_total++; rd_beat_m++;
                if (rd_beat_m == BEATS_PER_TOKEN) begin
                    rd_beat_m = 0; void'(drain_q.pop_front()); rdy_cnt--; tok_out_m++;
                end
            end
            if (acc) begin
                acc_total++; wr_part++;
                if (wr_part == BEATS_PER_TOKEN) begin
                    wr_part = 0;
                    st_q.push_back(tok_in_m % NUM_BANKS);
                    drain_q.push_back(tok_in_m % NUM_BANKS);
                    tok_in_m++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge i_clk); #1;
    endtask

    task automatic wait_tok(input int target, input int lim, input string nm);
        int n;
        n = 0;
        while (tok_out_m < target && n < lim) begin tick(); n++; end
        chk({nm, "_timeout"}, n < lim, 1);
    endtask

    task automatic wait_acc(input int base, input int cnt, input int lim, input string nm);
        int n;
        n = 0;
        while (acc_total - base < cnt && n < lim) begin tick(); n++; end
        chk({nm, "_timeout"}, n < lim, 1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_stats_start"}, o_stats_start, 0);
        chk({nm, "_stats_bank"}, o_stats_bank, 0);
        chk({nm, "_norm_valid"}, o_norm_valid, 0);
        chk({nm, "_norm_bank"}, o_norm_bank, 0);
        chk({nm, "_norm_beat"}, o_norm_beat, 0);
        chk({nm, "_wr_bank"}, o_wr_bank, 0);
        chk({nm, "_wr_beat"}, o_wr_beat, 0);
        chk({nm, "_tok_in"}, o_tok_in, 0);
        chk({nm, "_tok_out"}, o_tok_out, 0);
        chk({nm, "_err"}, o_err, 0);
    endtask

    initial begin
        int base, n, b0;
        i_rst = 1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 0;
        tick();
        check_zero("reset");
        chk("reset_in_ready", o_in_ready, 0);
        en_low = 0;

        // single token, stats answers 5 cycles after start
        budget = 12; valid_pct = 100; ready_pct = 100; resp_delay = 5;
        wait_tok(1, 300, "single");

        // five back-to-back tokens against a stalled normalize stage
        ready_pct = 0; resp_delay = 0; base = acc_total; budget = 60;
        wait_acc(base, 48, 400, "stall_fill");
        repeat (40) tick();
        chk("stall_beats", acc_total - base, 48);
        chk("stall_in_ready", o_in_ready, 0);
        chk("stall_norm_valid", o_norm_valid, 1);
        ready_pct = 100;
        wait_tok(6, 600, "stall_drain");

        // egress ready toggling every cycle
        ready_pct = -1; budget = 12;
        wait_tok(7, 400, "toggle");

        // enable dropped mid-fill, then mid-drain
        ready_pct = 0; base = acc_total; budget = 12;
        wait_acc(base, 6, 200, "en_fill");
        en_low = 1;
        repeat (5) tick();
        chk("en_low_fill_hold", acc_total - base, 6);
        en_low = 0;
        wait_acc(base, 12, 200, "en_fill_rest");
        repeat (15) tick();
        ready_pct = 100; base = fire_total;
        n = 0;
        while (fire_total - base < 4 && n < 200) begin tick(); n++; end
        chk("en_drain_timeout", n < 200, 1);
        en_low = 1;
        repeat (4) tick();
        chk("en_low_drain_hold", fire_total - base, 4);
        en_low = 0;
        wait_tok(8, 200, "en_drain");

        // randomized traffic with enable drops and random stats latency
        en_drop_pct = 10; valid_pct = 70; ready_pct = 50; resp_delay = 0; budget = 180;
        wait_tok(23, 8000, "random");
        en_drop_pct = 0; valid_pct = 100; ready_pct = 100;
        repeat (3) tick();

        // reset while bank 1 is part-filled
        b0 = ((1 - (tok_in_m % NUM_BANKS) + NUM_BANKS) % NUM_BANKS) * 12 + 4;
        base = acc_total; budget = b0;
        wait_acc(base, b0, 600, "prefill");
        chk("prefill_bank1_beat4", wr_part, 4);
        @(posedge i_clk); #1 i_rst = 1;
        @(posedge i_clk); #1 i_rst = 0;
        tick();
        check_zero("midreset");

        // wrong-bank stats completion while bank 0 is in stats
        resp_delay = 8; budget = 12;
        n = 0;
        while (!o_stats_start && n < 100) begin tick(); n++; end
        chk("err_start_timeout", n < 100, 1);
        chk("err_start_bank", o_stats_bank, 0);
        inj_bank = 2'd2; inj_req = 1;
        repeat (3) tick();
        chk("err_set", o_err, 1);
        chk("err_no_drain", o_norm_valid, 0);
        wait_tok(1, 200, "err_token");
        inj_bank = 2'd1; inj_req = 1;
        repeat (3) tick();
        chk("err_sticky", o_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
